// File: rtl/apb_completer_regs_pkg.sv
// Shared register offsets, field widths and FSM state type for the APB completer.
package apb_completer_regs_pkg;

  localparam int unsigned REG_ID       = 32'h00;
  localparam int unsigned REG_CTRL     = 32'h04;
  localparam int unsigned REG_ERRCNT   = 32'h08;
  localparam int unsigned REG_SCRATCH0 = 32'h0C;

  localparam int WAIT_W   = 4;
  localparam int ERRCNT_W = 16;

  typedef enum logic {
    CPL_IDLE,
    CPL_ACCESS
  } apb_cpl_state_t;

endpackage

// File: rtl/apb_completer_regs_if.sv
// APB3 bus bundle between the bridge requester (master) and a completer (slave).
interface apb_completer_regs_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_completer_regs.sv
// APB3 register-file completer: ID, CTRL.WAIT, saturating ERRCNT, scratch words.
// Completes CTRL.WAIT cycles after the first access cycle; pready holds the bus otherwise.
module apb_completer_regs
  import apb_completer_regs_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0002_F000,
  parameter int                    DEPTH      = 16,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA2B0_0001
) (
  input logic                 clk,
  input logic                 rst_n,
  apb_completer_regs_if.slave apb
);

  localparam int                    IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(DEPTH * 4);
  localparam logic [IDX_W-1:0]      IDX_ID    = IDX_W'(REG_ID >> 2);
  localparam logic [IDX_W-1:0]      IDX_CTRL  = IDX_W'(REG_CTRL >> 2);
  localparam logic [IDX_W-1:0]      IDX_ERR   = IDX_W'(REG_ERRCNT >> 2);
  localparam logic [IDX_W-1:0]      IDX_SCR0  = IDX_W'(REG_SCRATCH0 >> 2);

  apb_cpl_state_t        state;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [WAIT_W-1:0]     ctrl_wait;
  logic [ERRCNT_W-1:0]   err_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0]      lat_idx;
  logic                  lat_write;
  logic                  lat_err;

  logic [ADDR_WIDTH-1:0] offset;
  logic [IDX_W-1:0]      idx;
  logic                  in_range;
  logic                  ro_hit;
  logic                  setup_err;
  logic                  done_ok;
  logic                  violation;
  logic                  pready_w;
  logic                  pslverr_w;
  logic [DATA_WIDTH-1:0] rd_word;

  // Setup-phase decode; the only place paddr is looked at.
  always_comb begin
    offset    = apb.paddr - BASE_ADDR;
    idx       = offset[IDX_W+1:2];
    in_range  = (apb.paddr >= BASE_ADDR) && (offset < WIN_BYTES);
    ro_hit    = (idx < IDX_SCR0) && (idx != IDX_CTRL);
    setup_err = !in_range || (apb.paddr[1:0] != 2'b00) || (apb.pwrite && ro_hit);
  end

  always_comb begin
    case (lat_idx)
      IDX_ID:   rd_word = ID_VALUE;
      IDX_CTRL: rd_word = {{(DATA_WIDTH-WAIT_W){1'b0}}, ctrl_wait};
      IDX_ERR:  rd_word = {{(DATA_WIDTH-ERRCNT_W){1'b0}}, err_cnt};
      default:  rd_word = mem[lat_idx];
    endcase
  end

  // A bare access phase in IDLE is answered at once with an error.
  always_comb begin
    done_ok   = (state == CPL_ACCESS) && (wait_cnt == '0) && apb.psel;
    violation = (state == CPL_IDLE) && apb.psel && apb.penable;
    pready_w  = done_ok || violation;
    pslverr_w = (done_ok && lat_err) || violation;
  end

  assign apb.pready  = pready_w;
  assign apb.pslverr = pslverr_w;
  assign apb.prdata  = (done_ok && !lat_err && !lat_write) ? rd_word : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CPL_IDLE;
      wait_cnt  <= '0;
      ctrl_wait <= '0;
      err_cnt   <= '0;
      lat_idx   <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        CPL_IDLE: begin
          if (apb.psel && !apb.penable) begin
            lat_idx   <= idx;
            lat_write <= apb.pwrite;
            lat_err   <= setup_err;
            wait_cnt  <= ctrl_wait;
            state     <= CPL_ACCESS;
          end
        end
        CPL_ACCESS: begin
          if (!apb.psel) begin
            state <= CPL_IDLE;
          end else if (wait_cnt == '0) begin
            state <= CPL_IDLE;
            if (lat_write && !lat_err) begin
              if (lat_idx == IDX_CTRL) begin
                ctrl_wait <= apb.pwdata[WAIT_W-1:0];
              end else begin
                mem[lat_idx] <= apb.pwdata;
              end
            end
          end else if (apb.penable) begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= CPL_IDLE;
      endcase

      if (pready_w && pslverr_w && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule
